clk_prog_ctrl: RTL and testbench

Serial programming controller for the DCM_CLKGEN-based programmable clocks (CORE_CLK, CMP_CLK and spares). It sits directly upstream of the clock generation block. It accepts one M/D reprogramming command at a time from the host command path and drives the shared progclk/progdata lines and the per-clock progen[3:0] lines. After programming it waits for the combined progdone_inv, then pulses pll_reset and reports done or error.

---
 rtl/clk_prog_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_clk_prog_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_prog_ctrl.sv
// clk_prog_ctrl: serial M/D programming sequencer for DCM_CLKGEN clocks, with done wait and PLL reset.
module clk_prog_ctrl #(
  parameter int PROGCLK_DIV      = 1,
  parameter int TIMEOUT          = 65536,
  parameter int PLL_RESET_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       cmd_wr_en,
  input  logic [1:0] cmd_clk_num,
  input  logic [7:0] cmd_m,
  input  logic [7:0] cmd_d,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] progen,
  output logic       progdata,
  output logic       progclk,
  input  logic       progdone_inv,
  output logic       pll_reset
);
  localparam int DW   = PROGCLK_DIV > 1 ? $clog2(PROGCLK_DIV) : 1;
  localparam int CMAX = TIMEOUT > PLL_RESET_CYCLES ? TIMEOUT : PLL_RESET_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [3:0] {IDLE, START, LOAD_D, GAP1, LOAD_M, GAP2, GO, WAIT_DONE, PLL_RST} state_t;

  state_t        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    num_q, num_d;
  logic [7:0]    m_q, m_d, d_q, d_d;
  logic [3:0]    progen_q, progen_d;
  logic          progdata_q, progdata_d, progclk_q, progclk_d;
  logic          pll_reset_q, pll_reset_d, done_q, done_d, err_q, err_d;
  logic [1:0]    sync_q;
  logic          tog, tick, last;
  logic [3:0]    onehot;
  logic [2:0]    idx;

  assign busy     = state_q != IDLE;
  assign tog      = busy && (div_q == DW'(PROGCLK_DIV - 1));
  assign tick     = tog && progclk_q;
  assign onehot   = 4'b0001 << num_q;
  assign last     = step_q == 4'd9;
  // step s carries data bit s-2, and the bit is chosen one step ahead
  assign idx      = 3'(step_q - 4'd1);
  assign done     = done_q;
  assign err      = err_q;
  assign progen   = progen_q;
  assign progdata = progdata_q;
  assign progclk  = progclk_q;
  assign pll_reset = pll_reset_q;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    m_d         = m_q;
    d_d         = d_q;
    progen_d    = progen_q;
    progdata_d  = progdata_q;
    pll_reset_d = pll_reset_q;
    err_d       = err_q;
    done_d      = 1'b0;
    div_d       = (!busy || tog) ? '0 : div_q + 1'b1;
    progclk_d   = tog ? ~progclk_q : progclk_q;
    case (state_q)
      IDLE: if (cmd_wr_en) begin
        state_d = START;
        num_d   = cmd_clk_num;
        m_d     = cmd_m;
        d_d     = cmd_d;
        err_d   = 1'b0;
      end
      START: if (m_q == 8'd0) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else if (tick) begin
        state_d    = LOAD_D;
        step_d     = 4'd0;
        progen_d   = onehot;
        progdata_d = 1'b1;
      end
      LOAD_D: if (tick) begin
        state_d    = last ? GAP1 : LOAD_D;
        step_d     = last ? 4'd0 : step_q + 4'd1;
        progen_d   = last ? 4'd0 : onehot;
        progdata_d = !last && step_q != 4'd0 && d_q[idx];
      end
      GAP1: if (tick) begin
        state_d    = step_q == 4'd1 ? LOAD_M : GAP1;
        step_d     = step_q == 4'd1 ? 4'd0 : step_q + 4'd1;
        progen_d   = step_q == 4'd1 ? onehot : 4'd0;
        progdata_d = step_q == 4'd1;
      end
      LOAD_M: if (tick) begin
        state_d    = last ? GAP2 : LOAD_M;
        step_d     = last ? 4'd0 : step_q + 4'd1;
        progen_d   = last ? 4'd0 : onehot;
        progdata_d = !last && (step_q == 4'd0 || m_q[idx]);
      end
      GAP2: if (tick) begin
        state_d    = step_q == 4'd1 ? GO : GAP2;
        step_d     = step_q + 4'd1;
        progen_d   = step_q == 4'd1 ? onehot : 4'd0;
        progdata_d = 1'b0;
      end
      GO: if (tick) begin
        state_d    = WAIT_DONE;
        step_d     = 4'd0;
        cnt_d      = '0;
        progen_d   = 4'd0;
        progdata_d = 1'b0;
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        if (tick && step_q != 4'd4) step_d = step_q + 4'd1;
        if (step_q == 4'd4 && !sync_q[1]) begin
          state_d     = PLL_RST;
          cnt_d       = '0;
          pll_reset_d = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      PLL_RST: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(PLL_RESET_CYCLES - 1)) begin
          pll_reset_d = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // progclk must park low whenever the sequencer drops back to IDLE
    if (state_d == IDLE) begin
      progclk_d = 1'b0;
      div_d     = '0;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      cnt_q       <= '0;
      div_q       <= '0;
      num_q       <= '0;
      m_q         <= '0;
      d_q         <= '0;
      progen_q    <= '0;
      progdata_q  <= 1'b0;
      progclk_q   <= 1'b0;
      pll_reset_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sync_q      <= 2'b11;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      num_q       <= num_d;
      m_q         <= m_d;
      d_q         <= d_d;
      progen_q    <= progen_d;
      progdata_q  <= progdata_d;
      progclk_q   <= progclk_d;
      pll_reset_q <= pll_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
      sync_q      <= {sync_q[0], progdone_inv};
    end
  end
endmodule

// File: tb/tb_clk_prog_ctrl.sv
// tb_clk_prog_ctrl: scoreboard bench for clk_prog_ctrl; instances a/b share stimulus, c runs PROGCLK_DIV=3.
module tb_clk_prog_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rstn, wr, pdi;
  logic [1:0] num [2];
  logic [7:0] mv [2];
  logic [7:0] dv [2];
  logic [2:0] busy, done, err, pdat, pclk, pllr;
  logic [3:0] pen [3];

  int checks = 0, errors = 0;
  logic [4:0] bq [3][$];
  logic [1:0] rq [3][$];
  logic [2:0] busy_p = '0, pclk_p = '0, done_p = '0, pllr_p = '0, pll_seen = '0;
  int last_rise [3] = '{-1, -1, -1};
  int plen [3] = '{0, 0, 0};
  int rises [3] = '{0, 0, 0};
  int cyc = 0;

  clk_prog_ctrl u_a (.CLK(clk), .reset_n(rstn[0]), .cmd_wr_en(wr[0]), .cmd_clk_num(num[0]), .cmd_m(mv[0]),
    .cmd_d(dv[0]), .busy(busy[0]), .done(done[0]), .err(err[0]), .progen(pen[0]), .progdata(pdat[0]),
    .progclk(pclk[0]), .progdone_inv(pdi[0]), .pll_reset(pllr[0]));
  clk_prog_ctrl #(.TIMEOUT(64)) u_b (.CLK(clk), .reset_n(rstn[0]), .cmd_wr_en(wr[0]), .cmd_clk_num(num[0]),
    .cmd_m(mv[0]), .cmd_d(dv[0]), .busy(busy[1]), .done(done[1]), .err(err[1]), .progen(pen[1]),
    .progdata(pdat[1]), .progclk(pclk[1]), .progdone_inv(pdi[0]), .pll_reset(pllr[1]));
  clk_prog_ctrl #(.PROGCLK_DIV(3)) u_c (.CLK(clk), .reset_n(rstn[1]), .cmd_wr_en(wr[1]), .cmd_clk_num(num[1]),
    .cmd_m(mv[1]), .cmd_d(dv[1]), .busy(busy[2]), .done(done[2]), .err(err[2]), .progen(pen[2]),
    .progdata(pdat[2]), .progclk(pclk[2]), .progdone_inv(pdi[1]), .pll_reset(pllr[2]));

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int grp(int i);
    return i == 2 ? 1 : 0;
  endfunction

  task automatic push_cmd(int i, logic [1:0] n, logic [7:0] mm, logic [7:0] dd);
    logic [3:0] oh;
    oh = 4'b0001 << n;
    for (int k = 0; k < 10; k++) bq[i].push_back({oh, k == 0 ? 1'b1 : k == 1 ? 1'b0 : dd[k-2]});
    for (int k = 0; k < 10; k++) bq[i].push_back({oh, k < 2 ? 1'b1 : mm[k-2]});
    bq[i].push_back({oh, 1'b0});
    rq[i].push_back(2'b10);
  endtask

  task automatic issue(int g, logic [1:0] n, logic [7:0] mm, logic [7:0] dd);
    @(negedge clk);
    wr[g] = 1'b1; num[g] = n; mv[g] = mm; dv[g] = dd;
    @(negedge clk);
    wr[g] = 1'b0;
  endtask

  task automatic wait_idle(int i);
    int n = 0;
    while (busy[i] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle%0d", i), busy[i], 0);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (pclk[i] && !pclk_p[i]) begin
        rises[i]++;
        if (last_rise[i] >= 0) chk($sformatf("period%0d", i), cyc - last_rise[i], i == 2 ? 6 : 2);
        last_rise[i] = cyc;
        if (pen[i] != 4'd0) begin
          if (bq[i].size() == 0) chk($sformatf("extra_bit%0d", i), 1, 0);
          else chk($sformatf("bit%0d", i), {pen[i], pdat[i]}, bq[i].pop_front());
        end
      end
      if (!busy[i]) last_rise[i] = -1;
      if (!busy[i] && busy_p[i] && rstn[grp(i)]) begin
        if (rq[i].size() == 0) chk($sformatf("extra_result%0d", i), 1, 0);
        else chk($sformatf("result%0d", i), {done[i], err[i]}, rq[i].pop_front());
      end
      if (done_p[i]) chk($sformatf("done_width%0d", i), done[i], 0);
      if (pllr[i]) begin
        plen[i]++;
        pll_seen[i] = 1'b1;
      end else if (pllr_p[i]) begin
        chk($sformatf("pll_len%0d", i), plen[i], 16);
        plen[i] = 0;
      end
    end
    busy_p = busy; pclk_p = pclk; done_p = done; pllr_p = pllr;
    cyc++;
  end

  initial begin
    int n, to_n, r0;
    rstn = 2'b00; wr = 2'b00; pdi = 2'b00;
    num[0] = 0; num[1] = 0; mv[0] = 0; mv[1] = 0; dv[0] = 0; dv[1] = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("rst_outs%0d", i), {busy[i], done[i], err[i], pen[i], pdat[i], pclk[i], pllr[i]}, 0);
    rstn = 2'b11;

    push_cmd(0, 2'd1, 8'h0A, 8'h04);
    push_cmd(1, 2'd1, 8'h0A, 8'h04);
    issue(0, 2'd1, 8'h0A, 8'h04);
    chk("busy_rise", busy[0], 1);
    chk("clk_idle", pclk[0], 0);
    @(negedge clk);
    chk("clk_first_rise", pclk[0], 1);
    chk("pen_before_tick", pen[0], 0);
    @(negedge clk);
    chk("first_tick", {pclk[0], pen[0]}, 5'b00010);
    wait_idle(0);
    wait_idle(1);
    chk("err_after_ok", err[0], 0);
    chk("pll_seen_a", pll_seen[0], 1);

    pll_seen = '0;
    pdi[0] = 1'b1;
    push_cmd(0, 2'd1, 8'h0A, 8'h04);
    push_cmd(1, 2'd1, 8'h0A, 8'h04);
    void'(rq[1].pop_back());
    rq[1].push_back(2'b01);
    issue(0, 2'd1, 8'h0A, 8'h04);
    n = 0;
    while (bq[0].size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("go_reached", bq[0].size(), 0);
    to_n = 0;
    for (int k = 1; k <= 500; k++) begin
      @(negedge clk);
      if (err[1] && to_n == 0) to_n = k;
    end
    chk("timeout_window", int'(to_n >= 62 && to_n <= 68), 1);
    chk("timeout_no_pll", pll_seen[1], 0);
    chk("a_still_waiting", busy[0], 1);
    chk("a_no_pll_yet", pll_seen[0], 0);
    pdi[0] = 1'b0;
    n = 0;
    while (!done[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_latency", n, 19);

    push_cmd(0, 2'd2, 8'h55, 8'hA3);
    push_cmd(1, 2'd2, 8'h55, 8'hA3);
    issue(0, 2'd2, 8'h55, 8'hA3);
    chk("err_cleared", err[1], 0);
    n = 0;
    while (bq[0].size() > 8 && n < 200) begin
      @(posedge clk);
      n++;
    end
    issue(0, 2'd3, 8'hFF, 8'h00);
    chk("rewrite_busy", busy[0], 1);
    wait_idle(0);
    wait_idle(1);

    r0 = rises[0];
    rq[0].push_back(2'b01);
    rq[1].push_back(2'b01);
    issue(0, 2'd0, 8'h00, 8'h07);
    chk("m0_busy", busy[0], 1);
    @(negedge clk);
    chk("m0_idle", busy[0], 0);
    chk("m0_err", err[0], 1);
    repeat (5) @(negedge clk);
    chk("m0_no_clk", rises[0] - r0, 0);
    chk("m0_pen", pen[0], 0);

    push_cmd(2, 2'd3, 8'h12, 8'h34);
    issue(1, 2'd3, 8'h12, 8'h34);
    n = 0;
    while (bq[2].size() > 16 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("c_in_load_d", int'(bq[2].size() > 11), 1);
    #1 rstn[1] = 1'b0;
    #1 chk("async_rst", {busy[2], done[2], err[2], pen[2], pdat[2], pclk[2], pllr[2]}, 0);
    bq[2].delete();
    rq[2].delete();
    repeat (3) @(negedge clk);
    rstn[1] = 1'b1;
    push_cmd(2, 2'd0, 8'hC3, 8'h5A);
    issue(1, 2'd0, 8'hC3, 8'h5A);
    wait_idle(2);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) chk($sformatf("leftover%0d", i), bq[i].size() + rq[i].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
